// File: rtl/axis_multiport_pkt_gen_if.sv
// Bundled AXI4-Stream signals for NUM_PORTS parallel master streams.
// Port p occupies slice [p*W +: W] of each vector.
interface axis_multiport_pkt_gen_if #(
  parameter int DW = 64,
  parameter int UW = 128,
  parameter int NP = 5
);
  logic [NP*DW-1:0]   tdata;
  logic [NP*DW/8-1:0] tstrb;
  logic [NP*UW-1:0]   tuser;
  logic [NP-1:0]      tvalid;
  logic [NP-1:0]      tready;
  logic [NP-1:0]      tlast;

  modport master (
    output tdata, tstrb, tuser, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tuser, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/axis_multiport_pkt_gen.sv
// Ethernet-style AXI4-Stream frame generator: two header beats plus counter payload,
// sent on one of NUM_PORTS streams chosen per frame (fixed, round-robin or LFSR).
module axis_multiport_pkt_gen #(
  parameter int          C_M_AXIS_DATA_WIDTH  = 64,
  parameter int          C_M_AXIS_TUSER_WIDTH = 128,
  parameter int          NUM_PORTS            = 5,
  parameter logic [63:0] HDR_WORD_0           = 64'hEFBEFECAFECAFECA,
  parameter logic [63:0] HDR_WORD_1           = 64'h00000008EFBEEFBE,
  parameter logic [15:0] LFSR_SEED            = 16'hACE1
) (
  input  logic                     axi_aclk,
  input  logic                     axi_reset,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [2:0]               fixed_port,
  input  logic [7:0]               payload_len,
  input  logic [7:0]               gap_len,
  axis_multiport_pkt_gen_if.master m_axis,
  output logic                     busy,
  output logic [31:0]              pkt_count
);

  localparam int         DW       = C_M_AXIS_DATA_WIDTH;
  localparam int         UW       = C_M_AXIS_TUSER_WIDTH;
  localparam int         NP       = NUM_PORTS;
  localparam int         SW       = DW / 8;
  localparam logic [3:0] NP_W     = 4'(NP);
  localparam logic [7:0] NP_B     = 8'(NP);
  localparam logic [2:0] LAST_PRT = 3'(NP - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR0    = 3'd1,
    S_HDR1    = 3'd2,
    S_PAYLOAD = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       port_q, port_d;
  logic [2:0]       rr_q, rr_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       gap_q, gap_d;
  logic [7:0]       beat_q, beat_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [31:0]      pkt_count_q, pkt_count_d;
  logic             busy_q, busy_d;
  logic [NP-1:0]    tvalid_q, tvalid_d;
  logic [NP-1:0]    tlast_q, tlast_d;
  logic [NP*DW-1:0] tdata_q, tdata_d;
  logic [NP*SW-1:0] tstrb_q, tstrb_d;
  logic [NP*UW-1:0] tuser_q, tuser_d;
  logic             hs_s;
  logic             start_s;
  logic [DW-1:0]    payload_s;
  logic [UW-1:0]    user_s;

  // Frame sequencing, port selection and per-frame configuration latch
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    rr_d        = rr_q;
    len_d       = len_q;
    gap_d       = gap_q;
    beat_d      = beat_q;
    gap_cnt_d   = gap_cnt_q;
    lfsr_d      = lfsr_q;
    pkt_count_d = pkt_count_q;
    start_s     = 1'b0;
    hs_s        = tvalid_q[port_q] & m_axis.tready[port_q];

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          start_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR0: begin
        if (hs_s) begin
          state_d = S_HDR1;
        end else begin
          state_d = S_HDR0;
        end
      end
      S_HDR1: begin
        if (hs_s) begin
          state_d = S_PAYLOAD;
          beat_d  = 8'd0;
        end else begin
          state_d = S_HDR1;
        end
      end
      S_PAYLOAD: begin
        if (hs_s && (beat_q == len_q - 8'd1)) begin
          pkt_count_d = pkt_count_q + 32'd1;
          if (gap_q != 8'd0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_q;
          end else if (enable) begin
            start_s = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (hs_s) begin
          beat_d = beat_q + 8'd1;
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= 8'd1) begin
          if (enable) begin
            start_s = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The LFSR steps on every frame start so mode switches see a consistent sequence
    if (start_s) begin
      state_d = S_HDR0;
      beat_d  = 8'd0;
      len_d   = (payload_len == 8'd0) ? 8'd1 : payload_len;
      gap_d   = gap_len;
      lfsr_d  = lfsr_next(lfsr_q);
      case (mode)
        2'd1: begin
          port_d = rr_q;
          rr_d   = (rr_q == LAST_PRT) ? 3'd0 : rr_q + 3'd1;
        end
        2'd2: begin
          port_d = 3'(lfsr_q[7:0] % NP_B);
        end
        default: begin
          port_d = ({1'b0, fixed_port} >= NP_W) ? 3'd0 : fixed_port;
        end
      endcase
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // Next-cycle stream outputs derived from the next state, so a stall reproduces them
  always_comb begin
    tvalid_d  = '0;
    tlast_d   = '0;
    tdata_d   = '0;
    tstrb_d   = '0;
    tuser_d   = '0;
    payload_s = '0;
    user_s    = '0;
    busy_d    = (state_d != S_IDLE);

    for (int b = 0; b < SW; b++) begin
      payload_s[b*8 +: 8] = beat_d;
    end
    user_s[15:0]  = (16'(len_d) + 16'd2) * 16'(SW);
    user_s[23:16] = 8'd1 << port_d;

    if ((state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_PAYLOAD)) begin
      tvalid_d[port_d]                = 1'b1;
      tstrb_d[int'(port_d)*SW +: SW]  = {SW{1'b1}};
      tuser_d[int'(port_d)*UW +: UW]  = user_s;
      case (state_d)
        S_HDR0: begin
          tdata_d[int'(port_d)*DW +: DW] = DW'(HDR_WORD_0);
        end
        S_HDR1: begin
          tdata_d[int'(port_d)*DW +: DW] = DW'(HDR_WORD_1);
        end
        default: begin
          tdata_d[int'(port_d)*DW +: DW] = payload_s;
          tlast_d[port_d]                = (beat_d == len_d - 8'd1);
        end
      endcase
    end else begin
      tvalid_d = '0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q     <= S_IDLE;
      port_q      <= 3'd0;
      rr_q        <= 3'd0;
      len_q       <= 8'd1;
      gap_q       <= 8'd0;
      beat_q      <= 8'd0;
      gap_cnt_q   <= 8'd0;
      lfsr_q      <= LFSR_SEED;
      pkt_count_q <= 32'd0;
      busy_q      <= 1'b0;
      tvalid_q    <= '0;
      tlast_q     <= '0;
      tdata_q     <= '0;
      tstrb_q     <= '0;
      tuser_q     <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      rr_q        <= rr_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      beat_q      <= beat_d;
      gap_cnt_q   <= gap_cnt_d;
      lfsr_q      <= lfsr_d;
      pkt_count_q <= pkt_count_d;
      busy_q      <= busy_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      tstrb_q     <= tstrb_d;
      tuser_q     <= tuser_d;
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tstrb  = tstrb_q;
  assign m_axis.tuser  = tuser_q;
  assign busy          = busy_q;
  assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_multiport_pkt_gen.sv
// Scoreboard bench for axis_multiport_pkt_gen: expected beats are queued at stimulus
// time and a forked monitor pops them on every handshake.
module tb_axis_multiport_pkt_gen;

  localparam int          DW   = 64;
  localparam int          UW   = 128;
  localparam int          NP   = 5;
  localparam int          SW   = DW / 8;
  localparam logic [63:0] HDR0 = 64'hEFBEFECAFECAFECA;
  localparam logic [63:0] HDR1 = 64'h00000008EFBEEFBE;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct {
    int             port;
    logic [DW-1:0]  data;
    logic           last;
    logic [UW-1:0]  user;
    int             delta;
    bit             first;
  } beat_t;

  logic        clk = 1'b0;
  logic        axi_reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [2:0]  fixed_port = 3'd0;
  logic [7:0]  payload_len = 8'd1;
  logic [7:0]  gap_len = 8'd0;
  logic        busy;
  logic [31:0] pkt_count;

  axis_multiport_pkt_gen_if #(.DW(DW), .UW(UW), .NP(NP)) m_axis ();

  axis_multiport_pkt_gen #(
    .C_M_AXIS_DATA_WIDTH (DW),
    .C_M_AXIS_TUSER_WIDTH(UW),
    .NUM_PORTS           (NP),
    .HDR_WORD_0          (HDR0),
    .HDR_WORD_1          (HDR1),
    .LFSR_SEED           (SEED)
  ) dut (
    .axi_aclk   (clk),
    .axi_reset  (axi_reset),
    .enable     (enable),
    .mode       (mode),
    .fixed_port (fixed_port),
    .payload_len(payload_len),
    .gap_len    (gap_len),
    .m_axis     (m_axis),
    .busy       (busy),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            beats_popped = 0;
  int            last_tlast_cyc = 0;
  logic [NP-1:0] ports_hit = '0;
  bit            rand_ready = 1'b0;
  beat_t         sb_q[$];
  logic [15:0]   m_lfsr = SEED;
  int            m_rr = 0;
  int            m_pkts = 0;
  logic [NP-1:0] stall_prev = '0;
  logic [NP-1:0] hold_last;
  logic [DW-1:0] hold_data [NP];
  logic [UW-1:0] hold_user [NP];

  // tready changes just after the rising edge so it is stable when sampled
  initial begin
    m_axis.tready = '1;
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) m_axis.tready = NP'($urandom);
      else            m_axis.tready = '1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Spec-level port choice for the next frame start, advancing the reference LFSR
  function automatic int pick_port();
    int p;
    case (mode)
      2'd1: begin
        p    = m_rr;
        m_rr = (m_rr + 1) % NP;
      end
      2'd2: p = int'(m_lfsr[7:0]) % NP;
      default: p = (int'(fixed_port) >= NP) ? 0 : int'(fixed_port);
    endcase
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    return p;
  endfunction

  function automatic void push_frame(input int port, input int len_in, input int delta);
    beat_t b;
    int    len;
    len          = (len_in == 0) ? 1 : len_in;
    b.port       = port;
    b.user       = '0;
    b.user[15:0] = 16'((2 + len) * SW);
    b.user[23:16] = 8'(1 << port);
    b.data  = DW'(HDR0); b.last = 1'b0; b.delta = delta; b.first = 1'b1;
    sb_q.push_back(b);
    b.data  = DW'(HDR1); b.delta = -1; b.first = 1'b0;
    sb_q.push_back(b);
    for (int k = 0; k < len; k++) begin
      for (int j = 0; j < SW; j++) b.data[j*8 +: 8] = 8'(k);
      b.last = (k == len - 1);
      sb_q.push_back(b);
    end
  endfunction

  task automatic monitor_loop();
    int    nv;
    logic  bad;
    beat_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (axi_reset) begin
        stall_prev = '0;
      end else begin
        nv = $countones(m_axis.tvalid);
        checks++;
        if (nv > 1) begin
          errors++;
          $display("FAIL onehot tvalid=%b", m_axis.tvalid);
        end
        bad = 1'b0;
        for (int p = 0; p < NP; p++) begin
          if (!m_axis.tvalid[p] && ((m_axis.tdata[p*DW +: DW] != '0) || (m_axis.tuser[p*UW +: UW] != '0) ||
              (m_axis.tstrb[p*SW +: SW] != '0) || m_axis.tlast[p])) bad = 1'b1;
        end
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL idle_port_zero tvalid=%b tlast=%b", m_axis.tvalid, m_axis.tlast);
        end
        for (int p = 0; p < NP; p++) begin
          if (stall_prev[p]) begin
            checks++;
            if (!m_axis.tvalid[p] || m_axis.tdata[p*DW +: DW] !== hold_data[p] ||
                m_axis.tuser[p*UW +: UW] !== hold_user[p] || m_axis.tlast[p] !== hold_last[p]) begin
              errors++;
              $display("FAIL stall_hold port=%0d valid=%b data=%h expected data=%h", p,
                       m_axis.tvalid[p], m_axis.tdata[p*DW +: DW], hold_data[p]);
            end
          end
        end
        for (int p = 0; p < NP; p++) begin
          if (m_axis.tvalid[p] && m_axis.tready[p]) begin
            checks++;
            if (sb_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_beat port=%0d data=%h expected no beat", p, m_axis.tdata[p*DW +: DW]);
            end else begin
              e = sb_q.pop_front();
              if (p != e.port || m_axis.tdata[p*DW +: DW] !== e.data || m_axis.tlast[p] !== e.last ||
                  m_axis.tuser[p*UW +: UW] !== e.user || m_axis.tstrb[p*SW +: SW] !== {SW{1'b1}}) begin
                errors++;
                $display("FAIL beat got port=%0d data=%h last=%b user=%h strb=%h expected port=%0d data=%h last=%b user=%h",
                         p, m_axis.tdata[p*DW +: DW], m_axis.tlast[p], m_axis.tuser[p*UW +: UW],
                         m_axis.tstrb[p*SW +: SW], e.port, e.data, e.last, e.user);
              end
              if (e.first && e.delta >= 0) chk("hdr0_spacing", 32'(cyc - last_tlast_cyc), 32'(e.delta));
            end
            if (m_axis.tlast[p]) last_tlast_cyc = cyc;
            ports_hit[p] = 1'b1;
            beats_popped++;
          end
        end
        for (int p = 0; p < NP; p++) begin
          stall_prev[p] = m_axis.tvalid[p] & ~m_axis.tready[p];
          hold_data[p]  = m_axis.tdata[p*DW +: DW];
          hold_user[p]  = m_axis.tuser[p*UW +: UW];
          hold_last[p]  = m_axis.tlast[p];
        end
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_tvalid"}, 32'(m_axis.tvalid), 32'd0);
    chk({tag, "_tlast"}, 32'(m_axis.tlast), 32'd0);
    chk({tag, "_data_or"}, 32'(|{m_axis.tdata, m_axis.tuser, m_axis.tstrb}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pkt_count"}, pkt_count, 32'd0);
  endtask

  // Queue n frames, enable, drop enable once drop_after beats of this run are seen
  task automatic run_frames(input string tag, input int n, input int drop_after);
    int base;
    int t;
    base = beats_popped;
    for (int i = 0; i < n; i++) begin
      push_frame(pick_port(), int'(payload_len), (i == 0 || rand_ready) ? -1 : int'(gap_len) + 1);
      m_pkts++;
    end
    @(negedge clk);
    enable = 1'b1;
    t = 0;
    while (beats_popped < base + drop_after && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) chk({tag, "_start_timeout"}, 32'd1, 32'd0);
    enable = 1'b0;
    t = 0;
    while ((busy !== 1'b0 || sb_q.size() != 0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) chk({tag, "_drain_timeout"}, 32'(sb_q.size()), 32'd0);
    chk({tag, "_pkt_count"}, pkt_count, 32'(m_pkts));
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    axi_reset = 1'b0;

    // T1: fixed port 2, 4 payload beats, 3-cycle gap, two frames to see the gap
    mode = 2'd0; fixed_port = 3'd2; payload_len = 8'd4; gap_len = 8'd3;
    run_frames("t1", 2, 7);

    // T2: round-robin back-to-back over 7 frames -> ports 0,1,2,3,4,0,1
    mode = 2'd1; payload_len = 8'd2; gap_len = 8'd0;
    run_frames("t2", 7, 6 * 4 + 1);

    // T3: T1 frame with random backpressure
    mode = 2'd0; fixed_port = 3'd2; payload_len = 8'd4; gap_len = 8'd3;
    rand_ready = 1'b1;
    run_frames("t3", 1, 1);
    rand_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // T4: enable dropped during payload beat 1 on the highest port
    fixed_port = 3'd4; payload_len = 8'd8; gap_len = 8'd2;
    run_frames("t4", 1, 3);
    repeat (4) @(negedge clk);
    chk("t4_idle_busy", 32'(busy), 32'd0);

    // T5: LFSR port selection over 200 frames
    mode = 2'd2; payload_len = 8'd1; gap_len = 8'd0;
    ports_hit = '0;
    run_frames("t5", 200, 199 * 3 + 1);
    chk("t5_ports_hit", 32'(ports_hit), 32'(5'b11111));

    // T6: reset mid-payload, then payload_len=0 with an out-of-range fixed port
    mode = 2'd0; fixed_port = 3'd1; payload_len = 8'd6; gap_len = 8'd0;
    push_frame(pick_port(), 6, -1);
    begin
      int base;
      int t;
      base = beats_popped;
      @(negedge clk);
      enable = 1'b1;
      t = 0;
      while (beats_popped < base + 4 && t < 1000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 1000) chk("t6_start_timeout", 32'd1, 32'd0);
    end
    axi_reset = 1'b1;
    enable    = 1'b0;
    @(negedge clk);
    check_reset_state("t6_reset");
    axi_reset = 1'b0;
    sb_q.delete();
    m_lfsr = SEED;
    m_rr   = 0;
    m_pkts = 0;
    payload_len = 8'd0; fixed_port = 3'd7;
    run_frames("t6", 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
